// File: rtl/pll_lock_supervisor_pkg.sv
// pll_sup_pkg: supervisor states, default timing constants and the cnt width helper
package pll_sup_pkg;
  typedef enum logic [2:0] {S_PLLRST, S_WAIT, S_STABLE, S_RUN, S_FAULT} state_e;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_RETRY_MAX = 4;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: PLL-side signals; master=supervisor (in: locked, restart; out: pll_rst, sys_rst_out, ready, fault, retry_cnt, loss_cnt)
interface pll_lock_supervisor_if
  import pll_sup_pkg::*;
#(
  parameter int RETRY_MAX = DEF_RETRY_MAX
);
  logic locked;
  logic restart;
  logic pll_rst;
  logic sys_rst_out;
  logic ready;
  logic fault;
  logic [$clog2(RETRY_MAX+1)-1:0] retry_cnt;
  logic [7:0] loss_cnt;
  modport master(
    input locked, restart,
    output pll_rst, sys_rst_out, ready, fault, retry_cnt, loss_cnt
  );
  modport slave(
    output locked, restart,
    input pll_rst, sys_rst_out, ready, fault, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: 2-flop synchroniser, reset to 0 (clk, rst, async d in, synchronised q out)
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset/lock sequencer with retry, fault and loss counting (refclk, sync rst, bus=master modport)
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int RETRY_MAX = DEF_RETRY_MAX
) (
  input logic refclk,
  input logic rst,
  pll_lock_supervisor_if.master bus
);
  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RW = $clog2(RETRY_MAX + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0] loss_q, loss_d;
  logic pll_rst_q, pll_rst_d, sys_rst_q, sys_rst_d, ready_q, ready_d, fault_q, fault_d;
  logic locked_s, at_max;
  pll_lock_sync u_sync (.clk(refclk), .rst(rst), .d(bus.locked), .q(locked_s));
  assign at_max = retry_q == RW'(RETRY_MAX);
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    retry_d = retry_q;
    loss_d = loss_q;
    case (state_q)
      S_PLLRST:
        if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = S_WAIT;
        else cnt_d = cnt_q + 1'b1;
      S_WAIT:
        if (locked_s) state_d = S_STABLE;
        else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d = at_max ? S_FAULT : S_PLLRST;
          retry_d = at_max ? retry_q : retry_q + 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      // the WAIT cycle that first saw locked_s high is the first stable cycle
      S_STABLE:
        if (!locked_s) state_d = S_WAIT;
        else if (cnt_q == CW'(STABLE_CYCLES - 2)) state_d = S_RUN;
        else cnt_d = cnt_q + 1'b1;
      S_RUN:
        if (!locked_s) begin
          state_d = S_PLLRST;
          retry_d = '0;
          loss_d = loss_q + {7'd0, ~&loss_q};
        end
      S_FAULT:
        if (bus.restart) begin
          state_d = S_PLLRST;
          retry_d = '0;
        end
      default: state_d = S_PLLRST;
    endcase
    pll_rst_d = state_d == S_PLLRST || state_d == S_FAULT;
    sys_rst_d = state_d != S_RUN;
    ready_d = state_d == S_RUN;
    fault_d = state_d == S_FAULT;
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= S_PLLRST;
      cnt_q <= '0;
      retry_q <= '0;
      loss_q <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      retry_q <= retry_d;
      loss_q <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end
  assign bus.pll_rst = pll_rst_q;
  assign bus.sys_rst_out = sys_rst_q;
  assign bus.ready = ready_q;
  assign bus.fault = fault_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt = loss_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: table-driven and sequence checks of pll_lock_supervisor with a scoreboard queue
module tb_pll_lock_supervisor;
  logic refclk = 1'b0;
  logic rst = 1'b1;
  always #10 refclk = ~refclk;
  pll_lock_supervisor_if #(.RETRY_MAX(2)) bus ();
  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8),
    .RETRY_MAX(2)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic ready;
    logic fault;
    logic [1:0] retry;
    logic [7:0] loss;
  } out_t;
  typedef struct {
    string name;
    int n;
    logic lk;
    logic rs;
    logic rt;
    out_t exp;
  } vec_t;
  out_t sb[$];
  vec_t tbl[$];
  int n_chk = 0;
  int n_fail = 0;
  function automatic out_t o(input logic p, input logic s, input logic r, input logic f,
                             input logic [1:0] rc, input logic [7:0] lc);
    return '{p, s, r, f, rc, lc};
  endfunction
  task automatic drive(input int n, input logic lk, input logic rs, input logic rt);
    bus.locked = lk;
    bus.restart = rs;
    rst = rt;
    repeat (n) @(posedge refclk);
    #1;
  endtask
  task automatic check_out(input string name);
    out_t got, want;
    got = '{bus.pll_rst, bus.sys_rst_out, bus.ready, bus.fault, bus.retry_cnt, bus.loss_cnt};
    want = sb.pop_front();
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d loss=%0d, want pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d loss=%0d",
               name, got.pll_rst, got.sys_rst, got.ready, got.fault, got.retry, got.loss,
               want.pll_rst, want.sys_rst, want.ready, want.fault, want.retry, want.loss);
    end
  endtask
  task automatic step(input string name, input int n, input logic lk, input logic rs,
                      input logic rt, input out_t e);
    sb.push_back(e);
    drive(n, lk, rs, rt);
    check_out(name);
  endtask
  always @(negedge refclk) begin
    n_chk++;
    if (bus.sys_rst_out !== ~bus.ready || (bus.pll_rst && bus.ready)) begin
      n_fail++;
      $display("FAIL invariant: pll_rst=%b sys_rst_out=%b ready=%b", bus.pll_rst, bus.sys_rst_out, bus.ready);
    end
  end
  initial begin
    out_t rv;
    int k;
    bit ok;
    rv = o(1, 1, 0, 0, 0, 0);
    bus.locked = 1'b0;
    bus.restart = 1'b0;
    tbl.push_back('{"reset", 3, 0, 0, 1, rv});
    tbl.push_back('{"pllrst_hi", 3, 0, 0, 0, o(1, 1, 0, 0, 0, 0)});
    tbl.push_back('{"pllrst_fall", 1, 0, 0, 0, o(0, 1, 0, 0, 0, 0)});
    tbl.push_back('{"wait_unlocked", 3, 0, 0, 0, o(0, 1, 0, 0, 0, 0)});
    tbl.push_back('{"stable_hold", 9, 1, 0, 0, o(0, 1, 0, 0, 0, 0)});
    tbl.push_back('{"run_enter", 1, 1, 0, 0, o(0, 0, 1, 0, 0, 0)});
    tbl.push_back('{"loss_exit", 3, 0, 0, 0, o(1, 1, 0, 0, 0, 1)});
    tbl.push_back('{"relock_pllrst", 3, 1, 0, 0, o(1, 1, 0, 0, 0, 1)});
    tbl.push_back('{"relock_wait", 1, 1, 0, 0, o(0, 1, 0, 0, 0, 1)});
    tbl.push_back('{"relock_stable", 7, 1, 0, 0, o(0, 1, 0, 0, 0, 1)});
    tbl.push_back('{"relock_run", 1, 1, 0, 0, o(0, 0, 1, 0, 0, 1)});
    tbl.push_back('{"loss2", 3, 0, 0, 0, o(1, 1, 0, 0, 0, 2)});
    tbl.push_back('{"wait1", 4, 0, 0, 0, o(0, 1, 0, 0, 0, 2)});
    tbl.push_back('{"wait1_end", 19, 0, 0, 0, o(0, 1, 0, 0, 0, 2)});
    tbl.push_back('{"retry1", 1, 0, 0, 0, o(1, 1, 0, 0, 1, 2)});
    tbl.push_back('{"wait2", 4, 0, 0, 0, o(0, 1, 0, 0, 1, 2)});
    tbl.push_back('{"retry2", 20, 0, 0, 0, o(1, 1, 0, 0, 2, 2)});
    tbl.push_back('{"wait3", 4, 0, 0, 0, o(0, 1, 0, 0, 2, 2)});
    tbl.push_back('{"wait3_end", 19, 0, 0, 0, o(0, 1, 0, 0, 2, 2)});
    tbl.push_back('{"fault", 1, 0, 0, 0, o(1, 1, 0, 1, 2, 2)});
    tbl.push_back('{"fault_hold", 10, 0, 0, 0, o(1, 1, 0, 1, 2, 2)});
    tbl.push_back('{"restart", 1, 0, 1, 0, o(1, 1, 0, 0, 0, 2)});
    tbl.push_back('{"restart_pll", 3, 0, 0, 0, o(1, 1, 0, 0, 0, 2)});
    tbl.push_back('{"restart_wait", 1, 0, 0, 0, o(0, 1, 0, 0, 0, 2)});
    tbl.push_back('{"wait_pre", 17, 0, 0, 0, o(0, 1, 0, 0, 0, 2)});
    tbl.push_back('{"lock_at_timeout", 3, 1, 0, 0, o(0, 1, 0, 0, 0, 2)});
    tbl.push_back('{"late_stable", 6, 1, 0, 0, o(0, 1, 0, 0, 0, 2)});
    tbl.push_back('{"late_run", 1, 1, 0, 0, o(0, 0, 1, 0, 0, 2)});
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].name, tbl[i].n, tbl[i].lk, tbl[i].rs, tbl[i].rt, tbl[i].exp);
    step("glitch_rst", 2, 0, 0, 1, rv);
    step("glitch_pre", 7, 1, 0, 0, o(0, 1, 0, 0, 0, 0));
    step("glitch_low", 1, 0, 0, 0, o(0, 1, 0, 0, 0, 0));
    step("glitch_back", 2, 1, 0, 0, o(0, 1, 0, 0, 0, 0));
    step("glitch_no_early", 2, 1, 0, 0, o(0, 1, 0, 0, 0, 0));
    step("glitch_hold", 5, 1, 0, 0, o(0, 1, 0, 0, 0, 0));
    step("glitch_release", 1, 1, 0, 0, o(0, 0, 1, 0, 0, 0));
    step("sat_rst", 1, 1, 0, 1, rv);
    k = 0;
    while (k < 300) begin
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
        drive(1, 1, 0, 0);
        ok = bus.ready;
      end
      if (!ok) begin
        n_chk++;
        n_fail++;
        $display("FAIL sat_ready_timeout: ready=%b after 40 cycles, want 1 (loss %0d)", bus.ready, k);
        break;
      end
      drive(1, 0, 0, 0);
      drive(2, 1, 0, 0);
      k++;
      if (k == 254 || k == 255 || k == 256 || k == 300) begin
        sb.push_back(o(1, 1, 0, 0, 0, k > 255 ? 8'd255 : 8'(k)));
        check_out($sformatf("loss_after_%0d", k));
      end
    end
    step("stable_pre", 6, 1, 0, 0, o(0, 1, 0, 0, 0, 255));
    step("rst_in_stable", 1, 1, 0, 1, rv);
    step("fault_reach", 72, 0, 0, 0, o(1, 1, 0, 1, 2, 0));
    step("rst_in_fault", 1, 0, 0, 1, rv);
    step("post_rst_pll", 3, 0, 0, 0, o(1, 1, 0, 0, 0, 0));
    @(negedge refclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
